// File: rtl/key_debouncer_if.sv
// Key bus between the raw button lines, the debouncer and the panel controller.
// Every key signal is active-low.
interface key_debouncer_if #(
  parameter int N_KEYS = 7
);
  logic [N_KEYS-1:0] keys_raw;
  logic [N_KEYS-1:0] keys;
  logic [N_KEYS-1:0] key_state;

  modport master (
    output keys_raw,
    input  keys,
    input  key_state
  );

  modport slave (
    input  keys_raw,
    output keys,
    output key_state
  );
endinterface

// File: rtl/key_debouncer.sv
// Synchronizes and debounces active-low keys.
// Issues one single-cycle, one-hot-low event per press episode.
module key_debouncer #(
  parameter int N_KEYS          = 7,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  key_debouncer_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HELD
  } st_t;

  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] keys_q;
  logic [N_KEYS-1:0] pick;
  logic [CNT_W-1:0]  cnt [N_KEYS];
  st_t               st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= bus.keys_raw;
      s2 <= s1;
    end
  end

  // A bounce back to the stable level restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '1;
      for (int i = 0; i < N_KEYS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest pressed index wins.
  always_comb begin
    pick = '1;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (!stable[i]) begin
        pick    = '1;
        pick[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= IDLE;
      keys_q <= '1;
    end else begin
      unique case (st)
        IDLE: begin
          if (stable != '1) begin
            keys_q <= pick;
            st     <= HELD;
          end else begin
            keys_q <= '1;
          end
        end
        HELD: begin
          keys_q <= '1;
          if (stable == '1)
            st <= IDLE;
        end
        default: begin
          keys_q <= '1;
          st     <= IDLE;
        end
      endcase
    end
  end

  assign bus.keys      = keys_q;
  assign bus.key_state = stable;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, N_KEYS=7.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_key_debouncer;

  localparam int NK = 7;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  key_debouncer_if #(.N_KEYS(NK)) bus ();

  key_debouncer #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.keys_raw = 7'h7E;
    idle_wait(3);
    checks++;
    if (bus.keys !== 7'h7F) begin
      errors++;
      $display("FAIL reset_keys got=%h exp=7f", bus.keys);
    end
    checks++;
    if (bus.key_state !== 7'h7F) begin
      errors++;
      $display("FAIL reset_state got=%h exp=7f", bus.key_state);
    end
    rst = 1'b1;
    for (int e = 0; e < 10; e++) begin
      logic [NK-1:0] es;
      logic [NK-1:0] ek;
      step();
      es = (e >= 5) ? 7'h7E : 7'h7F;
      ek = (e == 6) ? 7'h7E : 7'h7F;
      checks++;
      if (bus.key_state !== es) begin
        errors++;
        $display("FAIL rst_lat_state e=%0d got=%h exp=%h",
                 e, bus.key_state, es);
      end
      checks++;
      if (bus.keys !== ek) begin
        errors++;
        $display("FAIL rst_lat_keys e=%0d got=%h exp=%h",
                 e, bus.keys, ek);
      end
    end
    bus.keys_raw = 7'h7F;
    idle_wait(10);
  endtask

  task automatic test_clean_press();
    int ev;
    int bad;
    ev = 0;
    bad = 0;
    bus.keys_raw = 7'h7D;
    for (int e = 0; e < 20; e++) begin
      step();
      if (bus.keys === 7'h7D) ev++;
      else if (bus.keys !== 7'h7F) bad++;
    end
    checks++;
    if (ev != 1 || bad != 0) begin
      errors++;
      $display("FAIL clean_event got=%0d/%0d exp=1/0", ev, bad);
    end
    bus.keys_raw = 7'h7F;
    for (int e = 0; e < 6; e++) begin
      logic [NK-1:0] es;
      step();
      es = (e >= 5) ? 7'h7F : 7'h7D;
      checks++;
      if (bus.key_state !== es) begin
        errors++;
        $display("FAIL clean_release e=%0d got=%h exp=%h",
                 e, bus.key_state, es);
      end
    end
    ev = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (bus.keys !== 7'h7F) ev++;
    end
    checks++;
    if (ev != 0) begin
      errors++;
      $display("FAIL clean_no_second got=%0d exp=0", ev);
    end
  endtask

  task automatic test_bounce();
    logic [NK-1:0] pat [8];
    int ev;
    pat = '{7'h7E, 7'h7E, 7'h7E, 7'h7F,
            7'h7E, 7'h7E, 7'h7E, 7'h7F};
    for (int i = 0; i < 14; i++) begin
      bus.keys_raw = (i < 8) ? pat[i] : 7'h7F;
      step();
      checks++;
      if (bus.key_state !== 7'h7F || bus.keys !== 7'h7F) begin
        errors++;
        $display("FAIL bounce i=%0d got=%h/%h exp=7f/7f",
                 i, bus.key_state, bus.keys);
      end
    end
    ev = 0;
    bus.keys_raw = 7'h7E;
    for (int e = 0; e < 10; e++) begin
      step();
      if (bus.keys === 7'h7E) ev++;
    end
    checks++;
    if (ev != 1) begin
      errors++;
      $display("FAIL bounce_hold got=%0d exp=1", ev);
    end
    bus.keys_raw = 7'h7F;
    idle_wait(10);
  endtask

  task automatic test_simultaneous();
    int e1;
    int e2;
    int ev;
    e1 = 0;
    e2 = 0;
    bus.keys_raw = 7'h79;
    for (int e = 0; e < 12; e++) begin
      step();
      if (bus.keys === 7'h7D) e1++;
      else if (bus.keys !== 7'h7F) e2++;
    end
    checks++;
    if (e1 != 1 || e2 != 0) begin
      errors++;
      $display("FAIL simul_first got=%0d/%0d exp=1/0", e1, e2);
    end
    ev = 0;
    bus.keys_raw = 7'h7B;
    for (int e = 0; e < 15; e++) begin
      step();
      if (bus.keys !== 7'h7F) ev++;
    end
    checks++;
    if (ev != 0) begin
      errors++;
      $display("FAIL simul_key2_held got=%0d exp=0", ev);
    end
    checks++;
    if (bus.key_state !== 7'h7B) begin
      errors++;
      $display("FAIL simul_state got=%h exp=7b", bus.key_state);
    end
    bus.keys_raw = 7'h7F;
    idle_wait(10);
    ev = 0;
    bus.keys_raw = 7'h7B;
    for (int e = 0; e < 12; e++) begin
      step();
      if (bus.keys === 7'h7B) ev++;
    end
    checks++;
    if (ev != 1) begin
      errors++;
      $display("FAIL simul_repress got=%0d exp=1", ev);
    end
    bus.keys_raw = 7'h7F;
    idle_wait(10);
  endtask

  task automatic test_reset_mid_count();
    bus.keys_raw = 7'h7E;
    idle_wait(4);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.key_state !== 7'h7F || bus.keys !== 7'h7F) begin
      errors++;
      $display("FAIL midrst_clear got=%h/%h exp=7f/7f",
               bus.key_state, bus.keys);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int e = 0; e < 9; e++) begin
      logic [NK-1:0] es;
      logic [NK-1:0] ek;
      step();
      es = (e >= 5) ? 7'h7E : 7'h7F;
      ek = (e == 6) ? 7'h7E : 7'h7F;
      checks++;
      if (bus.key_state !== es || bus.keys !== ek) begin
        errors++;
        $display("FAIL midrst e=%0d got=%h/%h exp=%h/%h",
                 e, bus.key_state, bus.keys, es, ek);
      end
    end
    bus.keys_raw = 7'h7F;
    idle_wait(10);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.keys_raw = 7'h7F;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
Front-end input stage that sits directly upstream of the panel controller.
It takes the raw, bouncing, active-low push-button lines and synchronizes and debounces each one.
It converts every press into a single-cycle, one-hot-low key event, because the controller acts on every clock edge on which it sees a key pattern.
Only one event is issued per press episode; no further event is issued until all keys are released.

Parameters:
N_KEYS, 7, number of key lines; matches the controller key bus width.
DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized level must differ from the stable level before it is accepted (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
CNT_W, 20, width of each per-key debounce counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; one clock; async assert, flops cleared immediately.
keys_raw  input  N_KEYS  raw button lines, active-low, asynchronous to clk.
keys  output  N_KEYS  key event to the controller, active-low; idle all-ones; at most one bit low, for exactly one cycle.
key_state  output  N_KEYS  debounced stable level per key, active-low; for the LED/debug path.

Behaviour:
- Reset (rst=0), all cleared asynchronously:
  - sync flops = all-ones.
  - key_state = all-ones.
  - debounce counters = 0.
  - FSM = IDLE.
  - keys = all-ones.
  - A reset asserted mid-press or mid-count abandons all progress. After release, a key held low must be re-debounced in full from zero.
- Synchronizer: 2-flop chain per bit (s1, s2). s2 is the only signal consumed downstream.
- Debounce, per key i, every edge:
  - If s2[i] == key_state[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1: key_state[i] <= s2[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - Consequence: key_state changes on the DEBOUNCE_CYCLES-th consecutive edge at which s2 differs from it. Any agreement in between (a bounce) restarts the count from 0.
  - Press and release are debounced identically.
- Latency: take edge 0 as the first edge that samples keys_raw[i] low.
  - s2 is low after edge 1.
  - key_state[i] is low after edge DEBOUNCE_CYCLES+1.
  - keys[i] is low for exactly the cycle following edge DEBOUNCE_CYCLES+2.
- FSM (registered output), state IDLE:
  - If key_state != all-ones: keys <= all-ones with only bit j cleared, where j is the lowest index with key_state[j]=0; go to HELD.
  - Otherwise: keys <= all-ones.
- FSM, state HELD:
  - keys <= all-ones.
  - If key_state == all-ones, go to IDLE on that edge. A new event may then be issued on the next edge.
- Simultaneous presses:
  - Keys debounced on the same edge produce a single event for the lowest index only.
  - A key that becomes stable low while in HELD never produces an event. It must be released, all keys must go idle, and it must be pressed again.
- Held key: no auto-repeat. keys stays all-ones for the whole hold time.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles never change key_state and never produce an event.
- keys is never a multi-bit-low pattern, so the controller's single-key decode is always satisfied.
- No combinational path from keys_raw to any output.

Test Plan:
(All with DEBOUNCE_CYCLES=4, N_KEYS=7.)
- Reset: hold rst=0 with keys_raw=7'h7E. Required: keys=7'h7F, key_state=7'h7F. Release rst with keys_raw still 7'h7E, edge 0 = first edge after release. Required: key_state=7'h7E after edge 5; keys=7'h7E only during the cycle after edge 6; keys=7'h7F thereafter.
- Clean press of key1: keys_raw=7'h7D held 20 cycles, then 7'h7F. Required:
  - Exactly one cycle of keys=7'h7D.
  - key_state returns to 7'h7F 5 edges after the raw release.
  - No second event.
- Bounce: keys_raw[0] toggles low for 3 cycles, high for 1, low for 3, then high. Required: key_state and keys remain 7'h7F throughout. Then hold low 10 cycles. Required: one event 7'h7E.
- Simultaneous press: keys_raw=7'h79 (keys 1 and 2 together). Required: one event keys=7'h7D, none for key2. Then release key1 only. Required: no event for key2 while it stays held. Release all and press key2. Required: keys=7'h7B once.
- Reset mid-count: keys_raw=7'h7E; pulse rst low for one cycle after edge 3. Required: no event before the full 4-cycle recount completes. The event appears 7 edges after rst deassertion, counting edge 0 as the first edge after release.
